// File: rtl/noc_pkg.sv
// Shared port enumeration, flit field helpers and XY route function
// for the parametrised five-port mesh router.
package noc_pkg;

  localparam int NPORTS      = 5;
  localparam int COORD_MAX_W = 16;

  typedef enum logic [2:0] {
    PORT_N = 3'd0,
    PORT_S = 3'd1,
    PORT_E = 3'd2,
    PORT_W = 3'd3,
    PORT_L = 3'd4
  } port_e;

  function automatic int head_pos(input int flit_w);
    return flit_w - 1;
  endfunction

  function automatic int tail_pos(input int flit_w);
    return flit_w - 2;
  endfunction

  // dest_x sits directly above dest_y in the head flit.
  function automatic int dest_x_lsb(input int y_w);
    return y_w;
  endfunction

  function automatic port_e xy_route(input logic [COORD_MAX_W-1:0] dest_x,
                                     input logic [COORD_MAX_W-1:0] dest_y,
                                     input logic [COORD_MAX_W-1:0] my_x,
                                     input logic [COORD_MAX_W-1:0] my_y);
    port_e r;
    if (dest_x > my_x)      r = PORT_E;
    else if (dest_x < my_x) r = PORT_W;
    else if (dest_y > my_y) r = PORT_N;
    else if (dest_y < my_y) r = PORT_S;
    else                    r = PORT_L;
    return r;
  endfunction

endpackage

// File: rtl/noc_in_fifo.sv
// Per-input circular flit buffer with a count register. Pop is resolved
// before the full check, so a full FIFO still accepts a flit on a pop cycle.
module noc_in_fifo #(
  parameter int FLIT_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [FLIT_W-1:0] flit_i,
  output logic [FLIT_W-1:0] front_o,
  output logic              empty_o,
  output logic              drop_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [FLIT_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              full;
  logic              wr_en;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full    = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign wr_en   = push_i && (!full || pop_i);
  assign drop_o  = push_i && full && !pop_i;
  assign front_o = mem_q[rd_ptr_q];

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q + CW'(wr_en) - CW'(pop_i);
    if (pop_i) rd_ptr_d = ptr_inc(rd_ptr_q);
    if (wr_en) wr_ptr_d = ptr_inc(wr_ptr_q);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= flit_i;
  end

endmodule

// File: rtl/noc_router_p.sv
// Five-port XY mesh router: wormhole switching with per-output round-robin
// arbitration, output locks and saturating credit counters.
module noc_router_p
  import noc_pkg::*;
#(
  parameter int FLIT_W  = 32,
  parameter int DEPTH   = 4,
  parameter int X_W     = 2,
  parameter int Y_W     = 2,
  parameter int CREDITS = DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [X_W-1:0]    my_x_i,
  input  logic [Y_W-1:0]    my_y_i,
  input  logic [FLIT_W-1:0] in_flit_i   [NPORTS],
  input  logic [NPORTS-1:0] in_valid_i,
  output logic [NPORTS-1:0] in_credit_o,
  output logic [FLIT_W-1:0] out_flit_o  [NPORTS],
  output logic [NPORTS-1:0] out_valid_o,
  input  logic [NPORTS-1:0] out_credit_i,
  output logic [NPORTS-1:0] overflow_o
);

  localparam int HEAD_BIT = head_pos(FLIT_W);
  localparam int TAIL_BIT = tail_pos(FLIT_W);
  localparam int DX_LSB   = dest_x_lsb(Y_W);
  localparam int CRED_W   = $clog2(CREDITS + 1);
  localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(CREDITS);

  logic [FLIT_W-1:0]      front_w [NPORTS];
  port_e                  req_port_w [NPORTS];
  logic [NPORTS-1:0]      empty_w, drop_w, pop_w, head_w, tail_w;
  logic [NPORTS-1:0]      xfer_w;
  logic [NPORTS-1:0][2:0] gsel_w;

  for (genvar gi = 0; gi < NPORTS; gi++) begin : g_in
    port_e route_q, route_d;
    port_e head_route;
    logic  pop;
    logic  credit_pulse_q;
    logic  ovf_q;

    noc_in_fifo #(
      .FLIT_W (FLIT_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (in_valid_i[gi]),
      .pop_i   (pop_w[gi]),
      .flit_i  (in_flit_i[gi]),
      .front_o (front_w[gi]),
      .empty_o (empty_w[gi]),
      .drop_o  (drop_w[gi])
    );

    assign head_w[gi] = front_w[gi][HEAD_BIT];
    assign tail_w[gi] = front_w[gi][TAIL_BIT];
    assign head_route = xy_route(COORD_MAX_W'(front_w[gi][DX_LSB +: X_W]),
                                 COORD_MAX_W'(front_w[gi][0 +: Y_W]),
                                 COORD_MAX_W'(my_x_i),
                                 COORD_MAX_W'(my_y_i));
    // Body and tail flits carry no address; they follow the latched route.
    assign req_port_w[gi] = head_w[gi] ? head_route : route_q;

    always_comb begin
      pop = 1'b0;
      for (int o = 0; o < NPORTS; o++) begin
        if (xfer_w[o] && (gsel_w[o] == 3'(gi))) pop = 1'b1;
      end
      route_d = (pop && head_w[gi]) ? head_route : route_q;
    end

    assign pop_w[gi] = pop;

    always_ff @(posedge clk) begin
      if (!rst) begin
        route_q        <= PORT_N;
        credit_pulse_q <= 1'b0;
        ovf_q          <= 1'b0;
      end else begin
        route_q        <= route_d;
        credit_pulse_q <= pop;
        ovf_q          <= ovf_q | drop_w[gi];
      end
    end

    assign in_credit_o[gi] = credit_pulse_q;
    assign overflow_o[gi]  = ovf_q;
  end

  for (genvar gi = 0; gi < NPORTS; gi++) begin : g_out
    logic [NPORTS-1:0] req;
    logic              gnt_valid;
    logic [2:0]        gnt_sel;
    logic              xfer;
    int                idx;
    logic              locked_q, locked_d;
    logic [2:0]        owner_q, owner_d;
    logic [2:0]        rr_q, rr_d;
    logic [CRED_W-1:0] credit_q, credit_d;
    logic              valid_q;
    logic [FLIT_W-1:0] flit_q, flit_d;

    always_comb begin
      req = '0;
      for (int p = 0; p < NPORTS; p++) begin
        req[p] = !empty_w[p] && (req_port_w[p] == port_e'(3'(gi)));
      end

      gnt_valid = 1'b0;
      gnt_sel   = owner_q;
      idx       = 0;
      if (locked_q) begin
        gnt_valid = req[owner_q];
      end else begin
        // Walk from farthest to nearest so the nearest head after rr_q wins.
        for (int k = NPORTS - 1; k >= 0; k--) begin
          idx = int'(rr_q) + k;
          if (idx >= NPORTS) idx = idx - NPORTS;
          if (req[idx] && head_w[idx]) begin
            gnt_valid = 1'b1;
            gnt_sel   = 3'(idx);
          end
        end
      end

      xfer     = gnt_valid && (credit_q != '0);
      locked_d = locked_q;
      owner_d  = owner_q;
      rr_d     = rr_q;
      if (xfer) begin
        if (locked_q) begin
          if (tail_w[gnt_sel]) locked_d = 1'b0;
        end else begin
          rr_d = (gnt_sel == 3'(NPORTS - 1)) ? 3'd0 : gnt_sel + 3'd1;
          if (!tail_w[gnt_sel]) begin
            locked_d = 1'b1;
            owner_d  = gnt_sel;
          end
        end
      end

      credit_d = credit_q;
      if (xfer && !out_credit_i[gi]) begin
        credit_d = credit_q - CRED_W'(1);
      end else if (!xfer && out_credit_i[gi] && (credit_q != CRED_MAX)) begin
        credit_d = credit_q + CRED_W'(1);
      end

      flit_d = xfer ? front_w[gnt_sel] : flit_q;
    end

    always_ff @(posedge clk) begin
      if (!rst) begin
        locked_q <= 1'b0;
        owner_q  <= '0;
        rr_q     <= '0;
        credit_q <= CRED_MAX;
        valid_q  <= 1'b0;
        flit_q   <= '0;
      end else begin
        locked_q <= locked_d;
        owner_q  <= owner_d;
        rr_q     <= rr_d;
        credit_q <= credit_d;
        valid_q  <= xfer;
        flit_q   <= flit_d;
      end
    end

    assign xfer_w[gi]      = xfer;
    assign gsel_w[gi]      = gnt_sel;
    assign out_valid_o[gi] = valid_q;
    assign out_flit_o[gi]  = flit_q;
  end

endmodule

// File: tb/tb_noc_router_p.sv
// Directed bench for noc_router_p at node (1,1): per-output scoreboard
// queues filled at stimulus time and drained as flits leave the router.
module tb_noc_router_p;

  localparam int FW = 32;
  localparam int NP = 5;
  localparam int N  = 0;
  localparam int S  = 1;
  localparam int E  = 2;
  localparam int W  = 3;
  localparam int L  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [1:0]    my_x = 2'd1;
  logic [1:0]    my_y = 2'd1;
  logic [FW-1:0] in_flit  [NP];
  logic [FW-1:0] out_flit [NP];
  logic [NP-1:0] in_valid, in_credit, out_valid, out_credit, overflow;

  int tests  = 0;
  int failed = 0;
  int cycle  = 0;
  logic [FW-1:0] exp_q [NP][$];
  int rx_cnt [NP];
  int inc_cnt [NP];
  int up_cred [NP];
  int last_cyc [NP];
  logic [NP-1:0] auto_ret;

  noc_router_p #(
    .FLIT_W  (32),
    .DEPTH   (4),
    .X_W     (2),
    .Y_W     (2),
    .CREDITS (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .my_x_i       (my_x),
    .my_y_i       (my_y),
    .in_flit_i    (in_flit),
    .in_valid_i   (in_valid),
    .in_credit_o  (in_credit),
    .out_flit_o   (out_flit),
    .out_valid_o  (out_valid),
    .out_credit_i (out_credit),
    .overflow_o   (overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [FW-1:0] mk(input logic h, input logic t, input int dx,
                                       input int dy, input int pl);
    return {h, t, 26'(pl), 2'(dx), 2'(dy)};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int p, input logic [FW-1:0] f);
    in_valid[p] = 1'b1;
    in_flit[p]  = f;
  endtask

  // Advance one edge, then score outputs and model the neighbours' credit links.
  task automatic tick();
    logic [FW-1:0] e;
    @(posedge clk);
    #1;
    cycle++;
    for (int o = 0; o < NP; o++) begin
      if (out_valid[o] === 1'b1) begin
        rx_cnt[o]++;
        last_cyc[o] = cycle;
        check($sformatf("sb_pending_out%0d", o), 64'(exp_q[o].size() != 0), 64'd1);
        if (exp_q[o].size() != 0) begin
          e = exp_q[o].pop_front();
          check($sformatf("sb_flit_out%0d", o), 64'(out_flit[o]), 64'(e));
        end
      end
    end
    for (int p = 0; p < NP; p++) begin
      if (in_credit[p] === 1'b1) begin
        inc_cnt[p]++;
        up_cred[p]++;
      end
    end
    in_valid = '0;
    for (int o = 0; o < NP; o++) out_credit[o] = auto_ret[o] && out_valid[o];
  endtask

  task automatic bench_reset();
    rst        = 1'b0;
    in_valid   = '0;
    out_credit = '0;
    tick();
    rst = 1'b1;
    for (int o = 0; o < NP; o++) begin
      exp_q[o].delete();
      rx_cnt[o]  = 0;
      inc_cnt[o] = 0;
      up_cred[o] = 4;
    end
    out_credit = '0;
    auto_ret   = '1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [FW-1:0] f;
    int sent;
    int start_c;
    in_valid   = '0;
    out_credit = '0;
    auto_ret   = '1;
    for (int p = 0; p < NP; p++) in_flit[p] = '0;
    bench_reset();
    bench_reset();

    // Reset state
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_credit", 64'(in_credit), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    for (int o = 0; o < NP; o++) check($sformatf("rst_out_flit%0d", o), 64'(out_flit[o]), 64'd0);

    // Single flit W->E, minimum latency
    f = mk(1, 1, 2, 1, 'h111);
    drive(W, f);
    exp_q[E].push_back(f);
    tick();
    check("lat_edge1_valid_E", 64'(out_valid[E]), 64'd0);
    tick();
    check("lat_edge2_valid_E", 64'(out_valid[E]), 64'd1);
    check("lat_in_credit_W", 64'(in_credit), 64'b01000);
    tick();
    check("lat_oneshot_valid", 64'(out_valid), 64'd0);
    check("lat_oneshot_credit", 64'(in_credit), 64'd0);

    // XY routing sweep from the local port
    bench_reset();
    f = mk(1, 1, 0, 1, 'h201); drive(L, f); exp_q[W].push_back(f); tick();
    f = mk(1, 1, 1, 2, 'h202); drive(L, f); exp_q[N].push_back(f); tick();
    f = mk(1, 1, 1, 0, 'h203); drive(L, f); exp_q[S].push_back(f); tick();
    f = mk(1, 1, 1, 1, 'h204); drive(L, f); exp_q[L].push_back(f); tick();
    f = mk(1, 1, 3, 0, 'h205); drive(L, f); exp_q[E].push_back(f); tick();
    repeat (4) tick();
    check("route_to_W", 64'(rx_cnt[W]), 64'd1);
    check("route_to_N", 64'(rx_cnt[N]), 64'd1);
    check("route_to_S", 64'(rx_cnt[S]), 64'd1);
    check("route_to_L", 64'(rx_cnt[L]), 64'd1);
    check("route_x_first_E", 64'(rx_cnt[E]), 64'd1);

    // Wormhole: 3-flit N->L packet locks L against a concurrent S head
    bench_reset();
    f = mk(1, 0, 1, 1, 'h301); drive(N, f); exp_q[L].push_back(f);
    f = mk(1, 1, 1, 1, 'h3F0); drive(S, f);
    tick();
    f = mk(0, 0, 0, 0, 'h302); drive(N, f); exp_q[L].push_back(f);
    tick();
    check("worm_head_L", 64'(out_valid[L]), 64'd1);
    f = mk(0, 1, 0, 0, 'h303); drive(N, f); exp_q[L].push_back(f);
    exp_q[L].push_back(mk(1, 1, 1, 1, 'h3F0));
    tick();
    check("worm_body_L", 64'(out_valid[L]), 64'd1);
    tick();
    check("worm_tail_L", 64'(out_valid[L]), 64'd1);
    tick();
    check("worm_next_head_L", 64'(out_valid[L]), 64'd1);
    tick();
    check("worm_idle_L", 64'(out_valid[L]), 64'd0);
    check("worm_queue_drained", 64'(exp_q[L].size()), 64'd0);

    // Round-robin: four inputs all to L, credits looped back
    bench_reset();
    for (int k = 0; k < 4; k++)
      for (int p = 0; p < 4; p++) exp_q[L].push_back(mk(1, 1, 1, 1, p * 16 + k));
    start_c = cycle;
    for (int k = 0; k < 4; k++) begin
      for (int p = 0; p < 4; p++) drive(p, mk(1, 1, 1, 1, p * 16 + k));
      tick();
    end
    for (int i = 0; i < 30 && rx_cnt[L] < 16; i++) tick();
    check("rr_count_L", 64'(rx_cnt[L]), 64'd16);
    check("rr_back_to_back", 64'(last_cyc[L] - start_c), 64'd17);
    for (int p = 0; p < 4; p++) check($sformatf("rr_in_credits%0d", p), 64'(inc_cnt[p]), 64'd4);

    // Credit exhaustion on E
    bench_reset();
    auto_ret[E] = 1'b0;
    sent = 0;
    for (int i = 0; i < 14; i++) begin
      if (sent < 6 && up_cred[W] > 0) begin
        f = mk(1, 1, 2, 1, 'h500 + sent);
        drive(W, f);
        up_cred[W]--;
        if (sent < 5) exp_q[E].push_back(f);
        sent++;
      end
      tick();
    end
    check("cred_all_sent", 64'(sent), 64'd6);
    check("cred_stall_at_4", 64'(rx_cnt[E]), 64'd4);
    out_credit[E] = 1'b1;
    tick();
    check("cred_pulse_edge", 64'(out_valid[E]), 64'd0);
    tick();
    check("cred_next_edge", 64'(out_valid[E]), 64'd1);
    tick();
    check("cred_only_one", 64'(out_valid[E]), 64'd0);
    repeat (3) tick();
    check("cred_total_5", 64'(rx_cnt[E]), 64'd5);

    // Overflow on input N with output N starved of credit
    bench_reset();
    auto_ret[N] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      f = mk(1, 1, 1, 2, 'h600 + i);
      drive(L, f);
      exp_q[N].push_back(f);
      tick();
    end
    for (int i = 0; i < 10 && rx_cnt[N] < 4; i++) tick();
    check("ovf_drain_credits", 64'(rx_cnt[N]), 64'd4);
    for (int i = 0; i < 5; i++) begin
      f = mk(1, 1, 1, 2, 'h700 + i);
      drive(N, f);
      if (i < 4) exp_q[N].push_back(f);
      tick();
      if (i == 3) check("ovf_not_yet", 64'(overflow), 64'd0);
    end
    check("ovf_set_N", 64'(overflow), 64'b00001);
    repeat (4) tick();
    check("ovf_stalled", 64'(rx_cnt[N]), 64'd4);
    for (int i = 0; i < 5; i++) begin
      out_credit[N] = 1'b1;
      tick();
    end
    repeat (4) tick();
    check("ovf_fifth_dropped", 64'(rx_cnt[N]), 64'd8);
    check("ovf_in_credits_N", 64'(inc_cnt[N]), 64'd4);
    check("ovf_sticky", 64'(overflow), 64'b00001);

    // Reset in the middle of a W->E packet
    bench_reset();
    f = mk(1, 0, 2, 1, 'h800);
    drive(W, f);
    exp_q[E].push_back(f);
    tick();
    tick();
    check("mid_head_out_E", 64'(out_valid[E]), 64'd1);
    bench_reset();
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_in_credit", 64'(in_credit), 64'd0);
    check("mid_rst_overflow", 64'(overflow), 64'd0);
    check("mid_rst_flit_E", 64'(out_flit[E]), 64'd0);
    auto_ret[E] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      f = mk(1, 1, 2, 0, 'h900 + i);
      drive(S, f);
      if (i < 4) exp_q[E].push_back(f);
      tick();
    end
    repeat (8) tick();
    check("mid_new_head_credits", 64'(rx_cnt[E]), 64'd4);
    check("mid_no_overflow", 64'(overflow), 64'd0);

    for (int o = 0; o < NP; o++) check($sformatf("final_queue_empty%0d", o), 64'(exp_q[o].size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
